// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: multi-cycle mult/multu/div/divu with
// HI/LO result registers and single-edge mthi/mtlo writes.
//
//   state | meaning
//   IDLE  | no operation in flight; mthi/mtlo accepted, new start accepted
//   RUN   | operation in flight; counter counts down to the result load
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        md_hazard
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_dz;

    logic               is_md;
    logic               is_div;
    logic               div_ovf;
    logic [31:0]        b_safe;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;

    assign is_md   = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign is_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign div_ovf = (md_op == OP_DIV) && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    // Dividing by 1 instead yields exactly the required 0x80000000 / 0 for the
    // overflow case and keeps zero divisors away from the divider.
    assign b_safe = ((B == 32'd0) || div_ovf) ? 32'd1 : B;

    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};
        quot_s = $signed(A) / $signed(b_safe);
        rem_s  = $signed(A) % $signed(b_safe);
        quot_u = A / b_safe;
        rem_u  = A % b_safe;
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (md_op)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_hi = rem_s;
                res_lo = quot_s;
            end
            OP_DIVU: begin
                res_hi = rem_u;
                res_lo = quot_u;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_dz <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && is_md) begin
                        pend_hi <= res_hi;
                        pend_lo <= res_lo;
                        pend_dz <= is_div && (B == 32'd0);
                        cnt     <= is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else if (md_op == OP_MTHI) begin
                        hi_q <= A;
                    end else if (md_op == OP_MTLO) begin
                        lo_q <= A;
                    end
                end
                RUN: begin
                    if (cnt == 32'd1) begin
                        if (!pend_dz) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        cnt   <= 32'd0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign HI        = hi_q;
    assign LO        = lo_q;
    assign md_hazard = start | busy;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table of operations with a HI/LO
// scoreboard, plus hand sequences for ignored starts, mthi in RUN and reset.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        md_hazard;

    int errors = 0;
    int checks = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .md_hazard(md_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        st;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty got 0 entries expected 1", name);
        end else begin
            e = sb.pop_front();
            chk({name, ".HI"}, HI, e.hi);
            chk({name, ".LO"}, LO, e.lo);
        end
    endtask

    // Called and returns at negedge+1; leaves the unit idle.
    task automatic run_vec(input vec_t v, input int idx);
        int bc = 0;
        int hz = 0;
        int guard = 0;
        string nm;
        exp_t e;
        nm = $sformatf("vec%0d", idx);
        start = v.st;
        md_op = v.op;
        A = v.a;
        B = v.b;
        e.hi = v.hi;
        e.lo = v.lo;
        sb.push_back(e);
        #1;
        if (md_hazard) hz++;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        A = $urandom;
        B = $urandom;
        #1;
        while (busy && guard < 100) begin
            bc++;
            if (md_hazard) hz++;
            tick();
            guard++;
        end
        chk({nm, ".busy_cycles"}, 32'(bc), 32'(v.n));
        chk({nm, ".hazard_cycles"}, 32'(hz), 32'(v.n + int'(v.st)));
        pop_check(nm);
    endtask

    vec_t vecs[10];

    initial begin
        int bc;
        exp_t e;
        vecs[0] = '{3'd1, 1'b1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{3'd2, 1'b1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{3'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd4, 1'b1, 32'd7, 32'd2, 10, 32'd1, 32'd3};
        vecs[4] = '{3'd5, 1'b1, 32'h11, 32'd0, 0, 32'h11, 32'd3};
        vecs[5] = '{3'd6, 1'b0, 32'h22, 32'd0, 0, 32'h11, 32'h22};
        vecs[6] = '{3'd3, 1'b1, 32'h1234, 32'd0, 10, 32'h11, 32'h22};
        vecs[7] = '{3'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000};
        vecs[8] = '{3'd5, 1'b1, 32'hDEAD_BEEF, 32'd0, 0, 32'hDEAD_BEEF, 32'h8000_0000};
        vecs[9] = '{3'd6, 1'b0, 32'h1234_5678, 32'd0, 0, 32'hDEAD_BEEF, 32'h1234_5678};

        reset = 1'b1;
        start = 1'b0;
        md_op = 3'd0;
        A = 32'd0;
        B = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset.HI", HI, 32'd0);
        chk("reset.LO", LO, 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.md_hazard", 32'(md_hazard), 32'd0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // multu 6x7 with a second start and an mthi arriving mid-run
        start = 1'b1;
        md_op = 3'd2;
        A = 32'd6;
        B = 32'd7;
        e.hi = 32'd0;
        e.lo = 32'd42;
        sb.push_back(e);
        tick();
        start = 1'b0;
        md_op = 3'd0;
        A = 32'd0;
        B = 32'd0;
        bc = 0;
        for (int c = 1; c <= 12; c++) begin
            if (busy) bc++;
            if (c == 2) begin
                start = 1'b1;
                md_op = 3'd4;
                A = 32'd100;
                B = 32'd3;
            end else if (c == 3) begin
                start = 1'b0;
                md_op = 3'd5;
                A = 32'h0000_0BAD;
            end else if (c == 4) begin
                md_op = 3'd0;
                A = 32'd0;
                chk("mthi_in_run.HI", HI, 32'hDEAD_BEEF);
            end
            tick();
        end
        chk("second_start.busy_cycles", 32'(bc), 32'd5);
        pop_check("second_start");

        // divu interrupted by reset at busy cycle 4
        start = 1'b1;
        md_op = 3'd4;
        A = 32'd100;
        B = 32'd3;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        tick();
        tick();
        tick();
        chk("pre_reset.busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_reset.busy", 32'(busy), 32'd0);
        chk("mid_reset.HI", HI, 32'd0);
        chk("mid_reset.LO", LO, 32'd0);
        for (int c = 0; c < 15; c++) tick();
        chk("post_reset.HI", HI, 32'd0);
        chk("post_reset.LO", LO, 32'd0);
        chk("post_reset.busy", 32'(busy), 32'd0);

        // reset and start in the same cycle
        reset = 1'b1;
        start = 1'b1;
        md_op = 3'd1;
        A = 32'd3;
        B = 32'd3;
        tick();
        reset = 1'b0;
        start = 1'b0;
        md_op = 3'd0;
        chk("reset_start.busy", 32'(busy), 32'd0);
        for (int c = 0; c < 7; c++) tick();
        chk("reset_start.LO", LO, 32'd0);

        // start with md_op 7 does nothing
        start = 1'b1;
        md_op = 3'd7;
        A = 32'h99;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        chk("op7.busy", 32'(busy), 32'd0);
        chk("op7.HI", HI, 32'd0);
        chk("op7.LO", LO, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
